dport_auxregs: RTL and testbench
================================

Name: dport_auxregs

Overview:
Register-bus slave downstream of the AXI3-to-simple-bus bridge; consumes its outaddr/outwdata/outwr/outreq/outwstrb and returns outrdata/outack/outerr.
Holds AUX request registers plus 16-byte TX and RX buffers, and sequences one DisplayPort AUX transaction per software start against the AUX channel engine.
Reports busy/done/reply status to software.

Parameters:
ADDR, 32, bus address width; only bits [5:2] decoded, rest ignored.
DATA, 32, bus data width; only 32 supported.
TIMEOUT, 65535, cycles from aux_start to forced completion; 0 disables.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
addr  in  ADDR  bus address (bridge outaddr)
wdata  in  DATA  write data
wstrb  in  DATA/8  byte strobes
wr  in  1  1=write, 0=read
req  in  1  request, held until ack
ack  out  1  one-cycle acknowledge
rdata  out  DATA  read data, valid with ack
err  out  1  error, valid with ack
aux_start  out  1  one-cycle transaction start
aux_cmd  out  4  AUX command
aux_addr  out  20  AUX address
aux_len  out  4  byte count minus 1
aux_txrd  in  1  engine consumes one TX byte
aux_txdata  out  8  current TX byte
aux_rxvalid  in  1  engine delivers one RX byte
aux_rxdata  in  8  RX byte
aux_done  in  1  transaction complete pulse
aux_reply  in  4  reply code, valid with aux_done
irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Reset: ack=0, err=0, rdata=0, aux_start=0, all registers/buffers/pointers 0, state IDLE, irq=0.
- Bus handshake: ack <= req & ~ack, so ack rises the cycle after req, lasts 1 cycle, no double ack while req is still high in the ack cycle. Write side effects and read capture both happen on the req & ~ack cycle.
- Map (addr[5:2]): 0 ADDR RW [19:0]; 1 CTRL RW [3:0] cmd, [7:4] len, bit31 start (write-1, self-clearing, reads 0); 2 STATUS; 3 IRQEN; 4-7 TXBUF (byte 0 = word 4 bits [7:0], little-endian); 8-11 RXBUF RO.
- STATUS: [0] busy; [1] done (W1C); [2] timeout; [3] rx overflow; [7:4] reply; [12:8] rx count 0..16.
- wstrb: applies per byte to ADDR, CTRL, TXBUF. wstrb=0 is an acked no-op.
- err=1 cases: addr[5:2] 12-15; write to RXBUF; write to ADDR/CTRL/TXBUF while busy, including start. An erroring write changes nothing. Error reads return 0.
- FSM IDLE -> BUSY on a CTRL write with bit31=1 (strobe byte 3 set) and busy=0:
  - aux_start=1 for the next cycle.
  - txptr=0, rxptr=0; done, timeout and overflow cleared; timer loaded.
- BUSY:
  - aux_txdata = txbuf[txptr]; 0 once txptr > len.
  - aux_txrd increments txptr, saturating at 16.
  - aux_rxvalid writes rxbuf[rxptr] and increments rxptr. At rxptr=16 the byte is dropped and overflow is set.
- BUSY -> IDLE on aux_done (latch reply, set done) or on timer expiry (set timeout and done, reply=0).
  - aux_done wins if both occur in the same cycle.
  - aux_done in IDLE is ignored.
- Bus access simultaneous with aux_rxvalid: the RXBUF read returns the pre-write value.
- Reset mid-transaction returns to IDLE immediately; no aux_start is generated.

Optional Feature:
AUXREGS_IRQ_EN.
- Defined: IRQEN bit0 RW; irq = done & IRQEN[0], registered; cleared by a W1C write to done.
- Undefined: IRQEN reads 0, writes are acked without error and ignored; irq tied 0.

Decomposition:
- Package dport_auxregs_pkg: register index localparams, STATUS bit positions, state encoding, AUX command codes (native write 8, native read 9).
- Sub-module dport_auxbuf: 16x8 byte buffer with a 32-bit word port and a byte port, instantiated twice (TX, RX).

Test Plan:
- Write ADDR=0x00202, TXBUF0=0x44332211, CTRL=0x80000038 -> aux_start pulse; aux_cmd=8, aux_addr=0x00202, aux_len=3; four aux_txrd yield 11,22,33,44, then 0.
- Read with 4 aux_rxvalid AA..DD, aux_done with reply=0 -> STATUS=0x0402 (count 4, done), RXBUF0=0xDDCCBBAA.
- Start while busy, and write to RXBUF -> ack with err=1; registers unchanged.
- 17 aux_rxvalid bytes -> count 16, overflow=1, byte 16 dropped.
- No aux_done, TIMEOUT=100 -> done=1 and timeout=1 at cycle 100 after start; W1C to done clears it (and irq when AUXREGS_IRQ_EN).
- req held 3 cycles -> exactly one ack, one write effect; unmapped addr 0x30 -> err=1, rdata=0.

Source files
------------

// File: rtl/dport_auxregs_pkg.sv
// Shared definitions for the DisplayPort AUX register slave: register map,
// STATUS bit positions, sequencer states, AUX command codes, byte-merge helper.
package dport_auxregs_pkg;

    localparam logic [3:0] REG_ADDR     = 4'd0;
    localparam logic [3:0] REG_CTRL     = 4'd1;
    localparam logic [3:0] REG_STATUS   = 4'd2;
    localparam logic [3:0] REG_IRQEN    = 4'd3;
    localparam logic [3:0] REG_TXBUF0   = 4'd4;
    localparam logic [3:0] REG_TXBUF1   = 4'd5;
    localparam logic [3:0] REG_TXBUF2   = 4'd6;
    localparam logic [3:0] REG_TXBUF3   = 4'd7;
    localparam logic [3:0] REG_RXBUF0   = 4'd8;
    localparam logic [3:0] REG_RXBUF1   = 4'd9;
    localparam logic [3:0] REG_RXBUF2   = 4'd10;
    localparam logic [3:0] REG_RXBUF3   = 4'd11;
    localparam logic [3:0] REG_UNMAPPED = 4'd12;

    localparam int ST_BUSY_BIT    = 0;
    localparam int ST_DONE_BIT    = 1;
    localparam int ST_TIMEOUT_BIT = 2;
    localparam int ST_OVF_BIT     = 3;
    localparam int CTRL_START_BIT = 31;

    localparam logic [3:0] AUX_CMD_NATIVE_WR = 4'd8;
    localparam logic [3:0] AUX_CMD_NATIVE_RD = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } aux_state_e;

    // Replace the bytes of cur selected by strb with the matching bytes of nxt.
    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] nxt,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dport_auxbuf.sv
// 16x8 byte buffer with a strobed 32-bit word port (little-endian) and a
// single-byte port; reads on both ports are combinational from the storage.
module dport_auxbuf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        word_we,
    input  logic [1:0]  word_idx,
    input  logic [31:0] word_wdata,
    input  logic [3:0]  word_strb,
    output logic [31:0] word_rdata,
    input  logic        byte_we,
    input  logic [3:0]  byte_idx,
    input  logic [7:0]  byte_wdata,
    output logic [7:0]  byte_rdata
);
    logic [7:0] mem_r [16];

    // Byte storage; a byte-port write takes precedence over a word write to the same byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (byte_we && (byte_idx == 4'(i))) begin
                    mem_r[i] <= byte_wdata;
                end else if (word_we && (word_idx == 2'(i / 4)) && word_strb[i % 4]) begin
                    mem_r[i] <= word_wdata[8*(i % 4) +: 8];
                end
            end
        end
    end

    assign word_rdata = {mem_r[{word_idx, 2'd3}], mem_r[{word_idx, 2'd2}],
                         mem_r[{word_idx, 2'd1}], mem_r[{word_idx, 2'd0}]};
    assign byte_rdata = mem_r[byte_idx];

endmodule

// File: rtl/dport_auxregs.sv
// DisplayPort AUX register slave: request registers, TX/RX buffers and a
// one-shot transaction sequencer. Define AUXREGS_IRQ_EN to enable the done interrupt.
module dport_auxregs
    import dport_auxregs_pkg::*;
#(
    parameter int ADDR    = 32,
    parameter int DATA    = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR-1:0]   addr,
    input  logic [DATA-1:0]   wdata,
    input  logic [DATA/8-1:0] wstrb,
    input  logic              wr,
    input  logic              req,
    output logic              ack,
    output logic [DATA-1:0]   rdata,
    output logic              err,
    output logic              aux_start,
    output logic [3:0]        aux_cmd,
    output logic [19:0]       aux_addr,
    output logic [3:0]        aux_len,
    input  logic              aux_txrd,
    output logic [7:0]        aux_txdata,
    input  logic              aux_rxvalid,
    input  logic [7:0]        aux_rxdata,
    input  logic              aux_done,
    input  logic [3:0]        aux_reply,
    output logic              irq
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    aux_state_e  state_r;
    logic        ack_r, err_r, aux_start_r;
    logic [31:0] rdata_r;
    logic [19:0] addr_r;
    logic [3:0]  cmd_r, len_r, reply_r;
    logic        done_r, timeout_r, ovf_r;
    logic [4:0]  txptr_r, rxptr_r;
    logic [TW-1:0] timer_r;

    logic        access_s, busy_s, err_s, wr_ok_s, start_s, done_clr_s;
    logic        tx_we_s, rx_we_s, timer_exp_s, irqen_s, unused_addr_s;
    logic [3:0]  idx_s;
    logic [31:0] rd_mux_s, tx_word_s, rx_word_s;
    logic [7:0]  tx_byte_s, rx_byte_unused_s, txdata_s;

    assign idx_s       = addr[5:2];
    assign unused_addr_s = ^{addr[ADDR-1:6], addr[1:0]};
    assign access_s    = req & ~ack_r;
    assign busy_s      = (state_r == ST_BUSY);
    assign wr_ok_s     = access_s & wr & ~err_s;
    assign start_s     = wr_ok_s & (idx_s == REG_CTRL) & wstrb[3] & wdata[CTRL_START_BIT];
    assign done_clr_s  = wr_ok_s & (idx_s == REG_STATUS) & wstrb[0] & wdata[ST_DONE_BIT];
    assign tx_we_s     = wr_ok_s & (idx_s[3:2] == 2'b01);
    assign rx_we_s     = busy_s & aux_rxvalid & ~rxptr_r[4];
    assign timer_exp_s = (TIMEOUT != 0) && (timer_r == TW'(1));

    // Error decode: unmapped words, RXBUF writes, request-register writes while busy.
    always_comb begin
        err_s = 1'b0;
        if (idx_s >= REG_UNMAPPED) begin
            err_s = 1'b1;
        end else if (wr && (idx_s >= REG_RXBUF0)) begin
            err_s = 1'b1;
        end else if (wr && busy_s && ((idx_s == REG_ADDR) || (idx_s == REG_CTRL) ||
                                      (idx_s >= REG_TXBUF0))) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Read data selection.
    always_comb begin
        rd_mux_s = 32'd0;
        case (idx_s)
            REG_ADDR:   rd_mux_s = {12'd0, addr_r};
            REG_CTRL:   rd_mux_s = {24'd0, len_r, cmd_r};
            REG_STATUS: rd_mux_s = {19'd0, rxptr_r, reply_r, ovf_r, timeout_r, done_r, busy_s};
            REG_IRQEN:  rd_mux_s = {31'd0, irqen_s};
            REG_TXBUF0, REG_TXBUF1, REG_TXBUF2, REG_TXBUF3: rd_mux_s = tx_word_s;
            REG_RXBUF0, REG_RXBUF1, REG_RXBUF2, REG_RXBUF3: rd_mux_s = rx_word_s;
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Bus handshake and software-owned request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
            addr_r  <= 20'd0;
            cmd_r   <= 4'd0;
            len_r   <= 4'd0;
        end else begin
            ack_r <= access_s;
            if (access_s) begin
                err_r   <= err_s;
                rdata_r <= (wr || err_s) ? 32'd0 : rd_mux_s;
            end else begin
                err_r   <= 1'b0;
            end
            if (wr_ok_s && (idx_s == REG_ADDR)) begin
                addr_r <= 20'(strb_merge({12'd0, addr_r}, wdata, wstrb));
            end
            if (wr_ok_s && (idx_s == REG_CTRL)) begin
                {len_r, cmd_r} <= 8'(strb_merge({24'd0, len_r, cmd_r}, wdata, wstrb));
            end
        end
    end

    // Transaction sequencer: start, byte pointers, timeout and completion status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            aux_start_r <= 1'b0;
            txptr_r     <= 5'd0;
            rxptr_r     <= 5'd0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            ovf_r       <= 1'b0;
            reply_r     <= 4'd0;
            timer_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_BUSY;
                        aux_start_r <= 1'b1;
                        txptr_r     <= 5'd0;
                        rxptr_r     <= 5'd0;
                        done_r      <= 1'b0;
                        timeout_r   <= 1'b0;
                        ovf_r       <= 1'b0;
                        timer_r     <= TW'(TIMEOUT);
                    end else begin
                        aux_start_r <= 1'b0;
                        if (done_clr_s) begin
                            done_r <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    aux_start_r <= 1'b0;
                    if (aux_txrd && !txptr_r[4]) begin
                        txptr_r <= txptr_r + 5'd1;
                    end
                    if (aux_rxvalid) begin
                        if (rxptr_r[4]) begin
                            ovf_r <= 1'b1;
                        end else begin
                            rxptr_r <= rxptr_r + 5'd1;
                        end
                    end
                    if (TIMEOUT != 0) begin
                        timer_r <= timer_r - TW'(1);
                    end
                    // Engine completion wins over a coincident timer expiry.
                    if (aux_done) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                        reply_r <= aux_reply;
                    end else if (timer_exp_s) begin
                        state_r   <= ST_IDLE;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        reply_r   <= 4'd0;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // TX byte presented to the engine; zero past the programmed length or when idle.
    always_comb begin
        txdata_s = 8'd0;
        if (busy_s && (txptr_r <= {1'b0, len_r})) begin
            txdata_s = tx_byte_s;
        end else begin
            txdata_s = 8'd0;
        end
    end

    dport_auxbuf u_txbuf (
        .clk        (clk),
        .resetn     (resetn),
        .word_we    (tx_we_s),
        .word_idx   (idx_s[1:0]),
        .word_wdata (wdata),
        .word_strb  (wstrb),
        .word_rdata (tx_word_s),
        .byte_we    (1'b0),
        .byte_idx   (txptr_r[3:0]),
        .byte_wdata (8'd0),
        .byte_rdata (tx_byte_s)
    );

    dport_auxbuf u_rxbuf (
        .clk        (clk),
        .resetn     (resetn),
        .word_we    (1'b0),
        .word_idx   (idx_s[1:0]),
        .word_wdata (32'd0),
        .word_strb  (4'd0),
        .word_rdata (rx_word_s),
        .byte_we    (rx_we_s),
        .byte_idx   (rxptr_r[3:0]),
        .byte_wdata (aux_rxdata),
        .byte_rdata (rx_byte_unused_s)
    );

`ifdef AUXREGS_IRQ_EN
    logic irqen_r, irq_r;

    // Interrupt enable register and registered interrupt output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irqen_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            if (wr_ok_s && (idx_s == REG_IRQEN) && wstrb[0]) begin
                irqen_r <= wdata[0];
            end
            irq_r <= done_r & irqen_r;
        end
    end

    assign irqen_s = irqen_r;
    assign irq     = irq_r;
`else
    assign irqen_s = 1'b0;
    assign irq     = 1'b0;
`endif

    assign ack        = ack_r;
    assign err        = err_r;
    assign rdata      = rdata_r;
    assign aux_start  = aux_start_r;
    assign aux_cmd    = cmd_r;
    assign aux_addr   = addr_r;
    assign aux_len    = len_r;
    assign aux_txdata = txdata_s;

endmodule

// File: tb/tb_dport_auxregs.sv
// Self-checking bench for dport_auxregs: register table plus AUX transaction
// sequences (TX, RX, overflow, timeout, busy errors, held req, reset mid-transfer).
`timescale 1ns/1ps
module tb_dport_auxregs;
    localparam int TMO = 100;
`ifdef AUXREGS_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0, resetn = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        wr = 1'b0, req = 1'b0;
    logic        ack, err, aux_start, irq;
    logic [31:0] rdata;
    logic [3:0]  aux_cmd, aux_len;
    logic [19:0] aux_addr;
    logic        aux_txrd = 1'b0, aux_rxvalid = 1'b0, aux_done = 1'b0;
    logic [7:0]  aux_txdata;
    logic [7:0]  aux_rxdata = 8'd0;
    logic [3:0]  aux_reply = 4'd0;

    int tests = 0, fails = 0, start_cnt = 0;

    dport_auxregs #(.ADDR(32), .DATA(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .wr(wr), .req(req), .ack(ack), .rdata(rdata), .err(err),
        .aux_start(aux_start), .aux_cmd(aux_cmd), .aux_addr(aux_addr), .aux_len(aux_len),
        .aux_txrd(aux_txrd), .aux_txdata(aux_txdata), .aux_rxvalid(aux_rxvalid),
        .aux_rxdata(aux_rxdata), .aux_done(aux_done), .aux_reply(aux_reply), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (aux_start) start_cnt <= start_cnt + 1;
    end

    typedef struct { string name; logic [31:0] rdata; logic err; bit chk_rd; } exp_t;
    typedef struct { string name; logic w; logic [5:0] a; logic [31:0] d; logic [3:0] s;
                     logic [31:0] er; logic ee; } vec_t;
    exp_t sb_q[$];
    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input string name, input logic w, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er, input logic ee);
        exp_t e;
        bit got;
        e.name = name; e.rdata = er; e.err = ee; e.chk_rd = !w;
        sb_q.push_back(e);
        req = 1'b1; wr = w; addr = {26'd0, a}; wdata = d; wstrb = s;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        req = 1'b0; wr = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            check({e.name, " ack"}, {31'd0, ack}, 32'd1);
        end else begin
            check({e.name, " err"}, {31'd0, err}, {31'd0, e.err});
            if (e.chk_rd) check({e.name, " rdata"}, rdata, e.rdata);
        end
    endtask

    task automatic pulse_txrd();
        aux_txrd = 1'b1; @(posedge clk); #1; aux_txrd = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        aux_rxvalid = 1'b1; aux_rxdata = b; @(posedge clk); #1; aux_rxvalid = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] r);
        aux_done = 1'b1; aux_reply = r; @(posedge clk); #1; aux_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, k, n;
        vt.push_back(vec_t'{"rst_status", 1'b0, 6'h08, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rst_addr",   1'b0, 6'h00, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rst_rxbuf",  1'b0, 6'h20, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"wr_addr",    1'b1, 6'h00, 32'h00000202, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_addr",    1'b0, 6'h00, 32'h0, 4'hF, 32'h00000202, 1'b0});
        vt.push_back(vec_t'{"wr_addr_b1", 1'b1, 6'h00, 32'hFFFFFFFF, 4'h2, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_addr_b1", 1'b0, 6'h00, 32'h0, 4'hF, 32'h0000FF02, 1'b0});
        vt.push_back(vec_t'{"wr_addr_b2", 1'b1, 6'h00, 32'hFFFFFFFF, 4'h4, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_addr_b2", 1'b0, 6'h00, 32'h0, 4'hF, 32'h000FFF02, 1'b0});
        vt.push_back(vec_t'{"wr_addr_s0", 1'b1, 6'h00, 32'h0, 4'h0, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_addr_s0", 1'b0, 6'h00, 32'h0, 4'hF, 32'h000FFF02, 1'b0});
        vt.push_back(vec_t'{"wr_addr2",   1'b1, 6'h00, 32'h00000202, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"wr_ctrl",    1'b1, 6'h04, 32'h00000038, 4'h1, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_ctrl",    1'b0, 6'h04, 32'h0, 4'hF, 32'h00000038, 1'b0});
        vt.push_back(vec_t'{"wr_tx0",     1'b1, 6'h10, 32'h44332211, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_tx0",     1'b0, 6'h10, 32'h0, 4'hF, 32'h44332211, 1'b0});
        vt.push_back(vec_t'{"wr_tx3",     1'b1, 6'h1C, 32'hA5A5A5A5, 4'h5, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_tx3",     1'b0, 6'h1C, 32'h0, 4'hF, 32'h00A500A5, 1'b0});
        vt.push_back(vec_t'{"wr_rxbuf",   1'b1, 6'h20, 32'h12345678, 4'hF, 32'h0, 1'b1});
        vt.push_back(vec_t'{"rd_rxbuf",   1'b0, 6'h20, 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_unmap30", 1'b0, 6'h30, 32'h0, 4'hF, 32'h0, 1'b1});
        vt.push_back(vec_t'{"wr_unmap3c", 1'b1, 6'h3C, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1});
        vt.push_back(vec_t'{"wr_irqen",   1'b1, 6'h0C, 32'h00000001, 4'hF, 32'h0, 1'b0});
        vt.push_back(vec_t'{"rd_irqen",   1'b0, 6'h0C, 32'h0, 4'hF, {31'd0, IRQ_ON}, 1'b0});
        vt.push_back(vec_t'{"rd_status",  1'b0, 6'h08, 32'h0, 4'hF, 32'h0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_start", {31'd0, aux_start}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) xfer(vt[i].name, vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].er, vt[i].ee);
        check("no_start_yet", 32'(start_cnt), 32'd0);

        // Native write: start pulse, request fields, TX byte stream.
        s0 = start_cnt;
        xfer("start_wr", 1'b1, 6'h04, 32'h80000038, 4'hF, 32'h0, 1'b0);
        check("start_hi", {31'd0, aux_start}, 32'd1);
        check("aux_cmd", {28'd0, aux_cmd}, 32'd8);
        check("aux_addr", {12'd0, aux_addr}, 32'h00202);
        check("aux_len", {28'd0, aux_len}, 32'd3);
        check("tx_b0", {24'd0, aux_txdata}, 32'h11);
        pulse_txrd();
        check("start_lo", {31'd0, aux_start}, 32'd0);
        check("tx_b1", {24'd0, aux_txdata}, 32'h22);
        pulse_txrd();
        check("tx_b2", {24'd0, aux_txdata}, 32'h33);
        pulse_txrd();
        check("tx_b3", {24'd0, aux_txdata}, 32'h44);
        pulse_txrd();
        check("tx_past_len", {24'd0, aux_txdata}, 32'h0);
        xfer("busy_start", 1'b1, 6'h04, 32'h80000039, 4'hF, 32'h0, 1'b1);
        xfer("busy_addr",  1'b1, 6'h00, 32'h000FFFFF, 4'hF, 32'h0, 1'b1);
        xfer("busy_tx",    1'b1, 6'h10, 32'h0, 4'hF, 32'h0, 1'b1);
        xfer("busy_rdctrl", 1'b0, 6'h04, 32'h0, 4'hF, 32'h00000038, 1'b0);
        xfer("busy_rdaddr", 1'b0, 6'h00, 32'h0, 4'hF, 32'h00000202, 1'b0);
        xfer("busy_rdtx",   1'b0, 6'h10, 32'h0, 4'hF, 32'h44332211, 1'b0);
        xfer("busy_status", 1'b0, 6'h08, 32'h0, 4'hF, 32'h00000001, 1'b0);
        check("one_start", 32'(start_cnt - s0), 32'd1);
        pulse_done(4'd5);
        xfer("wr_done_st", 1'b0, 6'h08, 32'h0, 4'hF, 32'h00000052, 1'b0);
        xfer("w1c_done",   1'b1, 6'h08, 32'h00000002, 4'hF, 32'h0, 1'b0);
        xfer("after_w1c",  1'b0, 6'h08, 32'h0, 4'hF, 32'h00000050, 1'b0);

        // Native read of four bytes.
        xfer("start_rd", 1'b1, 6'h04, 32'h80000039, 4'hF, 32'h0, 1'b0);
        check("aux_cmd_rd", {28'd0, aux_cmd}, 32'd9);
        pulse_rx(8'hAA); pulse_rx(8'hBB); pulse_rx(8'hCC); pulse_rx(8'hDD);
        pulse_done(4'd0);
        xfer("rd_status4", 1'b0, 6'h08, 32'h0, 4'hF, 32'h00000402, 1'b0);
        xfer("rd_rx0",     1'b0, 6'h20, 32'h0, 4'hF, 32'hDDCCBBAA, 1'b0);

        // RX byte landing in the same cycle as a bus read, then overflow.
        xfer("start_ovf", 1'b1, 6'h04, 32'h80000039, 4'hF, 32'h0, 1'b0);
        @(posedge clk); #1;
        aux_rxvalid = 1'b1; aux_rxdata = 8'h11;
        xfer("rx_same_cyc", 1'b0, 6'h20, 32'h0, 4'hF, 32'hDDCCBBAA, 1'b0);
        aux_rxvalid = 1'b0;
        xfer("rx_after", 1'b0, 6'h20, 32'h0, 4'hF, 32'hDDCCBB11, 1'b0);
        for (int i = 1; i <= 16; i++) pulse_rx(8'(8'h20 + i));
        xfer("ovf_status", 1'b0, 6'h08, 32'h0, 4'hF, 32'h00001009, 1'b0);
        xfer("ovf_rx3",    1'b0, 6'h2C, 32'h0, 4'hF, 32'h2F2E2D2C, 1'b0);
        pulse_done(4'hA);
        xfer("ovf_done",   1'b0, 6'h08, 32'h0, 4'hF, 32'h000010AA, 1'b0);
        pulse_done(4'h3);
        xfer("idle_done",  1'b0, 6'h08, 32'h0, 4'hF, 32'h000010AA, 1'b0);

        // Timeout: busy is visible as TX byte 0 on aux_txdata with len 0.
        xfer("start_tmo", 1'b1, 6'h04, 32'h80000008, 4'hF, 32'h0, 1'b0);
        check("tmo_busy", {24'd0, aux_txdata}, 32'h11);
        k = 201;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (aux_txdata == 8'h00) begin
                k = c;
                break;
            end
        end
        check("tmo_cycles", 32'(k), 32'(TMO));
        xfer("tmo_status", 1'b0, 6'h08, 32'h0, 4'hF, 32'h00000006, 1'b0);
        check("irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
        xfer("tmo_w1c", 1'b1, 6'h08, 32'h00000002, 4'hF, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("irq_clr", {31'd0, irq}, 32'd0);
        xfer("tmo_after", 1'b0, 6'h08, 32'h0, 4'hF, 32'h00000004, 1'b0);

        // req held across the ack cycle: exactly one ack.
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b1; addr = 32'h0; wdata = 32'h00012345; wstrb = 4'hF;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ack) n++;
            if (i == 1) begin
                req = 1'b0; wr = 1'b0;
            end
        end
        check("held_req_acks", 32'(n), 32'd1);
        xfer("held_rd", 1'b0, 6'h00, 32'h0, 4'hF, 32'h00012345, 1'b0);

        // Reset in the middle of a transaction.
        s0 = start_cnt;
        xfer("start_rst", 1'b1, 6'h04, 32'h80000038, 4'hF, 32'h0, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("rst_mid_txd", {24'd0, aux_txdata}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_starts", 32'(start_cnt - s0), 32'd1);
        check("rst_mid_len", {28'd0, aux_len}, 32'd0);
        xfer("rst_mid_status", 1'b0, 6'h08, 32'h0, 4'hF, 32'h0, 1'b0);
        xfer("rst_mid_tx0",    1'b0, 6'h10, 32'h0, 4'hF, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
